// File: rtl/ss_clk_pkg.sv
// Shared constants and types for the SS clock branch sequencer.
package ss_clk_pkg;

    localparam int SS_NBR          = 8;
    localparam int SS_STAGGER_DFLT = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_SETTLE = 1'b1
    } ss_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin first-one finder: returns the first set bit of
// PEND at or after PTR, wrapping from NBR-1 back to 0.
module rr_pick #(
    parameter int NBR = 8,
    parameter int PW  = 3
) (
    input  logic [NBR-1:0] PEND,
    input  logic [PW-1:0]  PTR,
    output logic           VALID,
    output logic [PW-1:0]  IDX
);

    // Walk offsets from far to near so the nearest hit after PTR wins.
    always_comb begin
        int j;
        j     = 0;
        VALID = 1'b0;
        IDX   = '0;
        for (int k = NBR - 1; k >= 0; k--) begin
            j = (int'(PTR) + k) % NBR;
            if (PEND[j]) begin
                VALID = 1'b1;
                IDX   = PW'(j);
            end
        end
    end

endmodule

// File: rtl/ss_clk_branch_seq.sv
// Sequencer for the gated SS clock tree: toggles one branch enable at a time
// and waits STAGGER cycles before acknowledging and taking the next decision.
module ss_clk_branch_seq
    import ss_clk_pkg::*;
#(
    parameter int NBR     = SS_NBR,
    parameter int STAGGER = SS_STAGGER_DFLT,
    parameter int CW      = 8
) (
    input  logic           RCC_CLK,
    input  logic           RCC_RST_N,
    input  logic [NBR-1:0] REQ,
    input  logic           ALL_OFF,
    output logic [NBR-1:0] CLK_EN,
    output logic [NBR-1:0] ACK,
    output logic           BUSY
);

    localparam int PW = (NBR > 1) ? $clog2(NBR) : 1;

    ss_state_e      state;
    logic [CW-1:0]  cnt;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  cur;
    logic [NBR-1:0] pend;
    logic           pick_vld;
    logic [PW-1:0]  pick_idx;

    // Branches whose enable disagrees with the request; ALL_OFF masks them all.
    assign pend = (REQ ^ CLK_EN) & ~{NBR{ALL_OFF}};

    rr_pick #(.NBR(NBR), .PW(PW)) u_pick (
        .PEND  (pend),
        .PTR   (ptr),
        .VALID (pick_vld),
        .IDX   (pick_idx)
    );

    // State is a flop, so BUSY has no path from any input.
    assign BUSY = (state == ST_SETTLE);

    // FSM: one toggle per IDLE decision, then count down the settle gap.
    always_ff @(posedge RCC_CLK or negedge RCC_RST_N) begin
        if (!RCC_RST_N) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            ptr    <= '0;
            cur    <= '0;
            CLK_EN <= '0;
            ACK    <= '0;
        end else if (ALL_OFF) begin
            // Abort everything, no acknowledge; keep ptr for fair resumption.
            state  <= ST_IDLE;
            cnt    <= '0;
            CLK_EN <= '0;
            ACK    <= '0;
        end else begin
            ACK <= '0;
            if (state == ST_IDLE) begin
                if (pick_vld) begin
                    CLK_EN[pick_idx] <= ~CLK_EN[pick_idx];
                    cur              <= pick_idx;
                    cnt              <= CW'(STAGGER - 1);
                    ptr              <= (pick_idx == PW'(NBR - 1)) ? '0 : pick_idx + PW'(1);
                    state            <= ST_SETTLE;
                end
            end else begin
                if (cnt != '0) begin
                    cnt <= cnt - CW'(1);
                end else begin
                    ACK[cur] <= 1'b1;
                    state    <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_ss_clk_branch_seq.sv
// Directed bench for ss_clk_branch_seq with NBR=8, STAGGER=4.
module tb_ss_clk_branch_seq;

    logic       RCC_CLK;
    logic       RCC_RST_N;
    logic [7:0] REQ;
    logic       ALL_OFF;
    logic [7:0] CLK_EN;
    logic [7:0] ACK;
    logic       BUSY;

    int checks = 0;
    int errors = 0;

    ss_clk_branch_seq #(.NBR(8), .STAGGER(4), .CW(8)) dut (
        .RCC_CLK   (RCC_CLK),
        .RCC_RST_N (RCC_RST_N),
        .REQ       (REQ),
        .ALL_OFF   (ALL_OFF),
        .CLK_EN    (CLK_EN),
        .ACK       (ACK),
        .BUSY      (BUSY)
    );

    initial RCC_CLK = 1'b0;
    always #5 RCC_CLK = ~RCC_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge RCC_CLK);
        #1;
    endtask

    task automatic do_reset();
        RCC_RST_N = 1'b0;
        REQ       = 8'h00;
        ALL_OFF   = 1'b0;
        tick();
        tick();
        RCC_RST_N = 1'b1;
    endtask

    // Service one branch: toggle edge, three settle edges, ACK edge.
    task automatic branch(input string tag, input logic [7:0] en_exp, input logic [7:0] ack_exp);
        tick();
        chk({tag, "_en"}, CLK_EN, en_exp);
        chk({tag, "_busy"}, BUSY, 1'b1);
        tick(); tick(); tick();
        chk({tag, "_noack"}, ACK, 8'h00);
        tick();
        chk({tag, "_ack"}, ACK, ack_exp);
        chk({tag, "_idle"}, BUSY, 1'b0);
    endtask

    initial begin
        logic [7:0] ones;
        logic [7:0] full;
        full = 8'hFF;

        // Reset state
        RCC_RST_N = 1'b0;
        REQ       = 8'h00;
        ALL_OFF   = 1'b0;
        #1;
        chk("rst_en", CLK_EN, 8'h00);
        chk("rst_ack", ACK, 8'h00);
        chk("rst_busy", BUSY, 1'b0);
        tick();
        RCC_RST_N = 1'b1;
        tick();
        chk("idle_en", CLK_EN, 8'h00);

        // Single branch: BUSY high exactly 4 cycles, ACK on the 4th edge
        REQ = 8'h01;
        tick();
        chk("s1_en", CLK_EN, 8'h01);
        chk("s1_busy0", BUSY, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            chk("s1_busy", BUSY, 1'b1);
            chk("s1_noack", ACK, 8'h00);
        end
        tick();
        chk("s1_ack", ACK, 8'h01);
        chk("s1_busy_end", BUSY, 1'b0);
        tick();
        chk("s1_ack_pulse", ACK, 8'h00);
        chk("s1_hold", CLK_EN, 8'h01);

        // Fill 0x00 -> 0xFF from PTR=0
        do_reset();
        REQ = 8'hFF;
        for (int i = 0; i < 8; i++) begin
            ones = full >> (7 - i);
            branch("fill", ones, 8'h01 << i);
        end
        tick();
        chk("fill_final", CLK_EN, 8'hFF);

        // Drain 0xFF -> 0x00, pointer has wrapped back to 0
        REQ = 8'h00;
        for (int i = 0; i < 8; i++) begin
            ones = full << (i + 1);
            branch("drain", ones, 8'h01 << i);
        end
        tick();
        chk("drain_final", CLK_EN, 8'h00);

        // Reversal during SETTLE is serviced afterwards, not cancelled
        REQ = 8'h04;
        tick();
        chk("rev_on", CLK_EN, 8'h04);
        REQ = 8'h00;
        tick(); tick(); tick();
        tick();
        chk("rev_ack1", ACK, 8'h04);
        chk("rev_still_on", CLK_EN, 8'h04);
        branch("rev_off", 8'h00, 8'h04);

        // ALL_OFF while branch 4 settles
        do_reset();
        REQ = 8'h1F;
        for (int i = 0; i < 4; i++) begin
            ones = full >> (7 - i);
            branch("ao_pre", ones, 8'h01 << i);
        end
        tick();
        chk("ao_b4_en", CLK_EN, 8'h1F);
        chk("ao_b4_busy", BUSY, 1'b1);
        tick();
        ALL_OFF = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("ao_en", CLK_EN, 8'h00);
            chk("ao_ack", ACK, 8'h00);
            chk("ao_busy", BUSY, 1'b0);
        end
        ALL_OFF = 1'b0;
        // PTR=5; nothing pending at 5..7, so wrap to 0..4
        for (int i = 0; i < 5; i++) begin
            ones = full >> (7 - i);
            branch("ao_resume", ones, 8'h01 << i);
        end

        // Asynchronous reset mid-SETTLE
        do_reset();
        REQ = 8'h01;
        tick();
        chk("ar_en", CLK_EN, 8'h01);
        tick();
        #2;
        RCC_RST_N = 1'b0;
        REQ       = 8'h00;
        #1;
        chk("ar_en_async", CLK_EN, 8'h00);
        chk("ar_busy_async", BUSY, 1'b0);
        chk("ar_ack_async", ACK, 8'h00);
        tick();
        RCC_RST_N = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            chk("ar_quiet_en", CLK_EN, 8'h00);
            chk("ar_quiet_ack", ACK, 8'h00);
            chk("ar_quiet_busy", BUSY, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
